// File: rtl/prio_code_pkg.sv
// Shared types for the 8:3 priority-coded request path.
// Used by both the encoder side and the decoder side.
package prio_code_pkg;

    localparam int CODE_W    = 3;
    localparam int NUM_LINES = 8;

    typedef logic [CODE_W-1:0] line_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        GAP
    } dec_state_t;

endpackage

// File: rtl/code_to_onehot.sv
// Combinational 3-to-8 line decoder.
// The parent registers its output.
module code_to_onehot
    import prio_code_pkg::*;
(
    input  logic [CODE_W-1:0]    code,
    output logic [NUM_LINES-1:0] onehot
);

    always_comb begin
        onehot       = '0;
        onehot[code] = 1'b1;
    end

endmodule

// File: rtl/prio_code_decoder.sv
// Receive side of the priority-coded request path.
// Drives one line until it acks (after a minimum hold) or times out.
module prio_code_decoder
    import prio_code_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int TIMEOUT     = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [CODE_W-1:0]    in_code,
    output logic                 in_ready,
    input  logic [NUM_LINES-1:0] ack,
    output logic [NUM_LINES-1:0] dec_out,
    output logic                 done,
    output logic                 timeout,
    output logic [7:0]           err_count
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] HOLD_K = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] TMO_K  = CW'(TIMEOUT);

    dec_state_t           state;
    line_idx_t            code_q;
    logic [CW-1:0]        cnt;
    logic                 ack_seen;
    logic [NUM_LINES-1:0] onehot;
    logic [CW-1:0]        k;
    logic                 seen_now;
    logic                 rel_ack;
    logic                 rel_tmo;

    code_to_onehot u_dec (
        .code   (in_code),
        .onehot (onehot)
    );

    // cnt holds completed drive cycles; k is the one ending now
    assign k        = cnt + 1'b1;
    assign seen_now = ack_seen | ack[code_q];
    assign rel_ack  = (k >= HOLD_K) && seen_now;
    assign rel_tmo  = (k == TMO_K);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            code_q    <= '0;
            cnt       <= '0;
            ack_seen  <= 1'b0;
            in_ready  <= 1'b1;
            dec_out   <= '0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            err_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        code_q   <= in_code;
                        cnt      <= '0;
                        ack_seen <= 1'b0;
                        dec_out  <= onehot;
                        in_ready <= 1'b0;
                        state    <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (rel_ack || rel_tmo) begin
                        dec_out <= '0;
                        done    <= rel_ack;
                        timeout <= !rel_ack;
                        if (!rel_ack && err_count != 8'hFF)
                            err_count <= err_count + 8'd1;
                        state   <= GAP;
                    end else begin
                        cnt      <= k;
                        ack_seen <= seen_now;
                    end
                end
                GAP: begin
                    done     <= 1'b0;
                    timeout  <= 1'b0;
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prio_code_decoder.sv
// Directed bench for prio_code_decoder.
// Per-transaction timeline model checked every cycle.
module tb_prio_code_decoder;

    localparam int H = 4;
    localparam int T = 15;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] in_code;
    logic       in_ready;
    logic [7:0] ack;
    logic [7:0] dec_out;
    logic       done;
    logic       timeout;
    logic [7:0] err_count;

    int checks;
    int errors;
    bit chk_en;

    logic [7:0] exp_dec;
    logic       exp_ready;
    logic       exp_done;
    logic       exp_to;
    logic [7:0] exp_err;

    int         run_len;
    int         last_len;
    logic [7:0] last_nz;

    prio_code_decoder #(
        .HOLD_CYCLES (H),
        .TIMEOUT     (T)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_code   (in_code),
        .in_ready  (in_ready),
        .ack       (ack),
        .dec_out   (dec_out),
        .done      (done),
        .timeout   (timeout),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, req);
        end
    endtask

    task automatic compare_cycle();
        check("dec_out", {24'h0, dec_out}, {24'h0, exp_dec});
        check("in_ready", {31'h0, in_ready}, {31'h0, exp_ready});
        check("done", {31'h0, done}, {31'h0, exp_done});
        check("timeout", {31'h0, timeout}, {31'h0, exp_to});
        check("err_count", {24'h0, err_count}, {24'h0, exp_err});
        if (dec_out != 8'h00) begin
            run_len++;
            last_nz = dec_out;
        end else if (run_len != 0) begin
            last_len = run_len;
            run_len  = 0;
        end
    endtask

    // Entered and left #1 after a rising edge, in an IDLE cycle.
    task automatic run_txn(input logic [2:0] code,
                           input int         ack_cyc,
                           input logic [7:0] noise,
                           input bit         hold_valid);
        int         len;
        bit         acked;
        logic [7:0] line;
        line  = 8'h01 << code;
        acked = (ack_cyc >= 1) && (ack_cyc <= T);
        if (acked)
            len = (ack_cyc > H) ? ack_cyc : H;
        else
            len = T;
        in_valid  = 1'b1;
        in_code   = code;
        ack       = noise;
        exp_dec   = 8'h00;
        exp_ready = 1'b1;
        exp_done  = 1'b0;
        exp_to    = 1'b0;
        for (int k = 1; k <= len; k++) begin
            @(posedge clk); #1;
            if (!hold_valid)
                in_valid = 1'b0;
            if (ack_cyc != 0 && k >= ack_cyc)
                ack = noise | line;
            else
                ack = noise;
            exp_dec   = line;
            exp_ready = 1'b0;
        end
        @(posedge clk); #1;
        ack      = noise | line;
        exp_dec  = 8'h00;
        exp_done = acked;
        exp_to   = !acked;
        if (!acked && exp_err != 8'hFF)
            exp_err = exp_err + 8'd1;
        @(posedge clk); #1;
        ack       = noise;
        exp_done  = 1'b0;
        exp_to    = 1'b0;
        exp_ready = 1'b1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        chk_en   = 1'b0;
        run_len  = 0;
        last_len = 0;
        last_nz  = 8'h00;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_code  = 3'd0;
        ack      = 8'h00;
        exp_dec  = 8'h00;
        exp_ready = 1'b1;
        exp_done = 1'b0;
        exp_to   = 1'b0;
        exp_err  = 8'h00;

        fork
            forever begin
                @(negedge clk);
                if (chk_en)
                    compare_cycle();
            end
        join_none

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        check("rst_dec", {24'h0, dec_out}, 32'h0);
        check("rst_ready", {31'h0, in_ready}, 32'h1);
        check("rst_err", {24'h0, err_count}, 32'h0);

        // basic: code 5, ack in drive cycle 2
        run_txn(3'd5, 2, 8'h00, 1'b0);
        check("basic_len", last_len, 4);
        check("basic_line", {24'h0, last_nz}, 32'h20);

        // late ack on line 0
        run_txn(3'd0, 9, 8'h00, 1'b0);
        check("late_len", last_len, 9);
        check("late_err", {24'h0, err_count}, 32'h0);

        // wrong-line acks only
        run_txn(3'd3, 0, 8'hF7, 1'b0);
        check("wrong_len", last_len, 15);
        check("wrong_line", {24'h0, last_nz}, 32'h08);
        check("wrong_err", {24'h0, err_count}, 32'h1);

        // ack arriving on the timeout cycle
        run_txn(3'd7, 15, 8'h00, 1'b0);
        check("tie_len", last_len, 15);
        check("tie_err", {24'h0, err_count}, 32'h1);

        // fastest turnaround with ack in cycle 1
        run_txn(3'd6, 1, 8'h3F, 1'b0);
        check("fast_len", last_len, 4);

        // reset in drive cycle 2
        chk_en   = 1'b0;
        run_len  = 0;
        in_valid = 1'b1;
        in_code  = 3'd4;
        ack      = 8'h00;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_dec", {24'h0, dec_out}, 32'h10);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_dec", {24'h0, dec_out}, 32'h0);
        check("mid_rst_done", {31'h0, done}, 32'h0);
        check("mid_rst_to", {31'h0, timeout}, 32'h0);
        check("mid_rst_err", {24'h0, err_count}, 32'h0);
        @(posedge clk); #1;
        check("rst_hold_done", {31'h0, done}, 32'h0);
        check("rst_hold_to", {31'h0, timeout}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", {31'h0, in_ready}, 32'h1);
        exp_dec   = 8'h00;
        exp_ready = 1'b1;
        exp_done  = 1'b0;
        exp_to    = 1'b0;
        exp_err   = 8'h00;
        chk_en    = 1'b1;
        run_txn(3'd2, 1, 8'h00, 1'b0);
        check("post_rst_line", {24'h0, last_nz}, 32'h04);

        // saturation with in_valid held high
        for (int i = 0; i < 256; i++)
            run_txn(3'(i), 0, 8'h00, 1'b1);
        in_valid = 1'b0;
        check("sat_err", {24'h0, err_count}, 32'hFF);
        check("sat_len", last_len, 15);

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prio_code_decoder.md
# prio_code_decoder

Receiving end of the 8:3 priority-encoded request path. Accepts a 3-bit line code through a valid/ready handshake and drives the matching one-hot line for at least `HOLD_CYCLES` clocks. It keeps driving until that line acknowledges or `TIMEOUT` clocks elapse, then reports completion or timeout. It sits between the request encoder's output and the eight per-line consumers.

## Interface
- `HOLD_CYCLES`, default 4: minimum number of cycles a decoded line is driven; range 1 to `TIMEOUT`-1.
- `TIMEOUT`, default 15: maximum number of drive cycles without an ack before abort.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: code present.
- `in_code` in 3: line index; 0 = line 0, 7 = line 7.
- `in_ready` out 1: block can accept a code.
- `ack` in 8: per-line acknowledge; only the bit of the active line is honoured.
- `dec_out` out 8: one-hot line drive, registered.
- `done` out 1: one-cycle pulse, transaction acked.
- `timeout` out 1: one-cycle pulse, transaction aborted.
- `err_count` out 8: saturating count of timeouts.

## Operation
- States: IDLE, DRIVE, GAP.
- **IDLE**
  - `in_ready`=1, `dec_out`=0.
  - On `in_valid & in_ready`, latch `in_code`, clear the drive counter and `ack_seen`, then go to DRIVE.
- **DRIVE**
  - `dec_out` = one-hot(latched code), `in_ready`=0. Drive cycles are numbered k = 1, 2, …
  - `ack_seen` sets when `ack[code]` is sampled high in any drive cycle. The current cycle's ack counts.
  - Release at the end of cycle k when (k ≥ `HOLD_CYCLES` and `ack_seen`) or k == `TIMEOUT`.
  - Ack wins over timeout in the same cycle.
- **GAP**
  - Exactly one cycle. `dec_out`=0, `in_ready`=0.
  - `done`=1 if released by ack; otherwise `timeout`=1 and `err_count` increments, saturating at 255.
  - Next state is IDLE.
- `ack` bits other than the latched code are ignored in all states. Any `ack` in IDLE or GAP is ignored.
- `in_valid` is ignored while `in_ready`=0. The upstream holds the code; there is no buffering.
- Widths: drive counter is `$clog2(TIMEOUT+1)` bits. `err_count` uses an 8-bit saturating add.
- Reset, asynchronous and valid at any time, including mid-DRIVE:
  - State goes to IDLE and the latched code is cleared.
  - `dec_out`=0, `done`=0, `timeout`=0, `err_count`=0.
  - `in_ready`=1 once `rst_n` is high.
  - Any in-flight transaction is discarded without a `done` or `timeout` pulse.

## Timing
- Accept at edge T. `dec_out` is one-hot from T+1.
- Acked transaction: `dec_out` is high for max(`HOLD_CYCLES`, ack cycle) cycles. The `done` pulse follows in the next cycle, and `in_ready` returns one cycle after that.
- Fastest turnaround, with ack present in drive cycle 1: `HOLD_CYCLES` + 2 cycles from accept to the next `in_ready`. With defaults this is 6.
- Timeout transaction: `dec_out` is high for exactly `TIMEOUT` cycles, followed by the `timeout` pulse.
- `dec_out` is never high in two consecutive transactions without at least one zero cycle, which is the GAP.
- `done` and `timeout` are mutually exclusive and are never high outside GAP.

## Structure
- Shared package `prio_code_pkg` contains:
  - `CODE_W`=3 and `NUM_LINES`=8.
  - State enum `dec_state_t` {IDLE, DRIVE, GAP}.
  - Line-index type shared with the encoder side.
- One sub-module: `code_to_onehot`, a purely combinational 3→8 decoder. Its output is registered in the parent.

## Test plan
- **Basic acked transaction**, defaults: send code 5 with `ack[5]` high in drive cycle 2.
  - `dec_out`=8'b0010_0000 for 4 cycles.
  - `done` pulses in cycle 5 after accept.
  - `in_ready` returns in cycle 6.
- **Late ack**: send code 0 with `ack[0]` in drive cycle 9.
  - `dec_out`=8'h01 for 9 cycles, then `done`.
  - `err_count` stays 0.
- **Wrong-line ack then timeout**: send code 3 with `ack`=8'hF7 held throughout.
  - `dec_out`=8'h08 for 15 cycles, then a `timeout` pulse.
  - `err_count`=1.
- **Ack and timeout in the same cycle**: `ack[7]` rises in drive cycle 15.
  - `done`=1, `timeout`=0, `err_count` unchanged.
- **Reset mid-DRIVE**: pull `rst_n` low in drive cycle 2.
  - `dec_out` goes to 0 immediately, with no `done` or `timeout` pulse.
  - After release, `in_ready`=1 and a new code 2 yields `dec_out`=8'h04.
- **Saturation and back-to-back**: run 256 timeouts.
  - `err_count` stays at 255.
  - `in_valid` held high with successive codes gives exactly one accept per transaction.
  - Every transaction ends with one GAP cycle where `dec_out`=0.
